// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
// Contents: FSM state enum, requester index constants, default widths.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } sram_arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int ADDR_W_DEF        = 11;
    localparam int DATA_W_DEF        = 8;
    localparam int ACCESS_CYCLES_DEF = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational two-requester winner select
// Ports: req0, req1 (requests), last (index served last), winner (chosen index).
// Build option: SRAM_ARB_FIXED_PRIO_EN makes requester 0 win every tie and ignores last.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = REQ_CPU;
        if (!req0 && req1) begin
            winner = REQ_DMA;
        end
    end
`else
    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = REQ_DMA;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM controller between a CPU and a DMA requester
// Ports: clk/reset (sync, active-high); per requester reqN, weN, addrN, wdataN in and
//        gntN, doneN out; rdata/busy status; sram_read/sram_write/sram_addr/sram_wdata
//        to the controller, sram_rdata from it. All outputs are registered.
// Build option: SRAM_ARB_FIXED_PRIO_EN (see sram_arb_pick) selects fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    sram_arb_state_e   state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d, rd_q, rd_d, wr_q, wr_d;
    logic              winner;

    sram_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_ACCESS;
                    owner_d = winner;
                    we_d    = (winner == REQ_DMA) ? we1    : we0;
                    addr_d  = (winner == REQ_DMA) ? addr1  : addr0;
                    wdata_d = (winner == REQ_DMA) ? wdata1 : wdata0;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    // Last command cycle: the controller's read data is on the bus now.
                    if (!we_q) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with it.
    always_comb begin
        gnt0_d  = (state_d != ST_IDLE) && (owner_d == REQ_CPU);
        gnt1_d  = (state_d != ST_IDLE) && (owner_d == REQ_DMA);
        done0_d = (state_d == ST_DONE) && (owner_d == REQ_CPU);
        done1_d = (state_d == ST_DONE) && (owner_d == REQ_DMA);
        busy_d  = (state_d == ST_ACCESS);
        rd_d    = (state_d == ST_ACCESS) && !we_d;
        wr_d    = (state_d == ST_ACCESS) && we_d;
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign busy       = busy_q;
    assign sram_read  = rd_q;
    assign sram_write = wr_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rdata      = rdata_q;

endmodule
